seq_loop_profiler: RTL

SEQ_LOOP_PROFILER -- requirements
Module: seq_loop_profiler

---
 rtl/seq_loop_profiler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seq_loop_profiler.sv
// Loop profiler: watches a one-hot accelerator FSM state and emits per-iteration
// latency records and a per-loop summary through a small show-ahead FIFO.
module seq_loop_profiler #(
  parameter int STATE_W    = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               clear,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] hdr_mask,
  input  logic [STATE_W-1:0] post_mask,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic               rec_kind,
  output logic [CNT_W-1:0]   rec_index,
  output logic [CNT_W-1:0]   rec_cycles,
  output logic               rec_sat,
  output logic               busy,
  output logic               overflow,
  output logic [15:0]        drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REC_W = 2 * CNT_W + 2;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_reg, state_next;
  logic               soft_rst;
  logic               hdr_hit, post_hit, hdr_entry;
  logic               hdr_hit_q_reg;
  logic [CNT_W-1:0]   idx_reg, lat_reg, total_reg;
  logic               sat_reg;
  logic               push, push_kind;
  logic [REC_W-1:0]   push_word;

  logic [REC_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               full, pop, do_push, drop;
  logic [REC_W-1:0]   head_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign soft_rst  = ~ap_rst_n | clear;
  assign hdr_hit   = |(cur_state & hdr_mask);
  assign post_hit  = |(cur_state & post_mask);
  assign hdr_entry = hdr_hit & ~hdr_hit_q_reg;

  // Edge detector keeps tracking through a soft clear so a held header is not re-counted.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) hdr_hit_q_reg <= 1'b0;
    else           hdr_hit_q_reg <= hdr_hit;
  end

  always_ff @(posedge ap_clk) begin
    if (soft_rst) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hdr_entry) state_next = ACTIVE;
      ACTIVE:  if (post_hit)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Exit wins over a coincident header entry.
  always_comb begin
    busy      = (state_reg == ACTIVE);
    push      = 1'b0;
    push_kind = 1'b0;
    if (state_reg == ACTIVE) begin
      if (post_hit) begin
        push      = 1'b1;
        push_kind = 1'b1;
      end else if (hdr_entry) begin
        push = 1'b1;
      end
    end
  end

  assign push_word = {push_kind, idx_reg, (push_kind ? total_reg : lat_reg), sat_reg};

  always_ff @(posedge ap_clk) begin
    if (soft_rst) begin
      idx_reg   <= '0;
      lat_reg   <= '0;
      total_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (hdr_entry) begin
        idx_reg   <= '0;
        lat_reg   <= CNT_W'(1);
        total_reg <= CNT_W'(1);
        sat_reg   <= 1'b0;
      end
    end else if (!post_hit) begin
      total_reg <= sat_inc(total_reg);
      if (hdr_entry) begin
        idx_reg <= sat_inc(idx_reg);
        lat_reg <= CNT_W'(1);
        sat_reg <= sat_reg | (&idx_reg) | (&total_reg);
      end else begin
        lat_reg <= sat_inc(lat_reg);
        sat_reg <= sat_reg | (&lat_reg) | (&total_reg);
      end
    end
  end

  // Record FIFO: a full FIFO still accepts a push when the head is popped in the same cycle.
  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = rec_valid & rec_ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge ap_clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge ap_clk) begin
    if (soft_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (soft_rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Outputs read as zero whenever nothing is queued.
  assign rec_valid  = (count_reg != '0);
  assign head_word  = rec_valid ? mem[rd_ptr_reg] : '0;
  assign rec_kind   = head_word[REC_W-1];
  assign rec_index  = head_word[REC_W-2 -: CNT_W];
  assign rec_cycles = head_word[CNT_W -: CNT_W];
  assign rec_sat    = head_word[0];

endmodule
